// File: rtl/uart_echo_pkg.sv
// Shared definitions for the UART echo FIFO: pop FSM encoding and the
// statistics counter width with its saturating increment.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } echo_state_e;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, exact occupancy and registered read data.
// Flush empties the FIFO and suppresses any push or pop in the same cycle.
module uart_sync_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PTR_W        = $clog2(FIFO_DEPTH)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [PAYLOAD_BITS-1:0] din,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    full,
    output logic                    empty,
    output logic [PTR_W:0]          level
);

    localparam logic [PTR_W:0] PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0] DEPTH_LVL = (PTR_W+1)'(FIFO_DEPTH);

    logic [PAYLOAD_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W:0]          wr_ptr_r;
    logic [PTR_W:0]          rd_ptr_r;
    logic [PAYLOAD_BITS-1:0] dout_r;
    logic                    do_push_s;
    logic                    do_pop_s;

    assign level     = wr_ptr_r - rd_ptr_r;
    assign full      = (level == DEPTH_LVL);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign dout      = dout_r;
    // Push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push_s = push && (!full || pop) && !flush;
    assign do_pop_s  = pop && !empty && !flush;

    // Storage array; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= din;
        end
    end

    // Pointer and read-data registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            dout_r   <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                dout_r   <= mem_r[rd_ptr_r[PTR_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered rx->tx echo bridge with overflow flag, BREAK flush and fill level.
// Optional statistics counters are enabled by defining UART_ECHO_STATS_EN.
module uart_echo_fifo
    import uart_echo_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PTR_W        = $clog2(FIFO_DEPTH)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [PAYLOAD_BITS-1:0] rx_data,
    input  logic                    rx_valid,
    input  logic                    rx_break,
    input  logic                    tx_busy,
    output logic                    tx_en,
    output logic [PAYLOAD_BITS-1:0] tx_data,
    output logic [PTR_W:0]          fifo_level,
    output logic                    overflow,
    input  logic                    ovf_clr,
    output logic [15:0]             rx_count,
    output logic [15:0]             drop_count
);

    echo_state_e state_r;
    echo_state_e state_next_s;
    logic        tx_en_r;
    logic        overflow_r;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        flush_s;
    logic        pop_s;
    logic        push_s;
    logic        drop_s;

    assign flush_s = rx_valid && rx_break;
    assign pop_s   = (state_r == ST_IDLE) && !fifo_empty_s && !tx_busy && !flush_s;
    assign push_s  = rx_valid && !rx_break && (!fifo_full_s || pop_s);
    assign drop_s  = rx_valid && !rx_break && fifo_full_s && !pop_s;

    uart_sync_fifo #(
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .PTR_W        (PTR_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_s),
        .pop    (pop_s),
        .flush  (flush_s),
        .din    (rx_data),
        .dout   (tx_data),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s),
        .level  (fifo_level)
    );

    // Pop FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) state_next_s = ST_LAUNCH;
                else       state_next_s = ST_IDLE;
            end
            ST_LAUNCH:  state_next_s = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (tx_busy) state_next_s = ST_WAIT_LO;
                else         state_next_s = ST_WAIT_HI;
            end
            ST_WAIT_LO: begin
                if (!tx_busy) state_next_s = ST_IDLE;
                else          state_next_s = ST_WAIT_LO;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state, launch strobe and sticky overflow; a new drop beats ovf_clr.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            tx_en_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            tx_en_r <= (state_next_s == ST_LAUNCH);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign tx_en    = tx_en_r;
    assign overflow = overflow_r;

`ifdef UART_ECHO_STATS_EN
    logic [CNT_W-1:0] rx_count_r;
    logic [CNT_W-1:0] drop_count_r;

    // Saturating frame statistics, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_count_r   <= '0;
            drop_count_r <= '0;
        end else begin
            if (push_s) rx_count_r <= sat_inc(rx_count_r);
            if (drop_s) drop_count_r <= sat_inc(drop_count_r);
        end
    end

    assign rx_count   = rx_count_r;
    assign drop_count = drop_count_r;
`else
    assign rx_count   = 16'h0000;
    assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed self-checking bench for uart_echo_fifo (16-deep, 8-bit payload).
module tb_uart_echo_fifo;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_break;
    logic       tx_busy;
    logic       tx_en;
    logic [7:0] tx_data;
    logic [4:0] fifo_level;
    logic       overflow;
    logic       ovf_clr;
    logic [15:0] rx_count;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_echo_fifo dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_break   (rx_break),
        .tx_busy    (tx_busy),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .rx_count   (rx_count),
        .drop_count (drop_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx_en(output logic got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_en === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Emulates uart_tx: catch the launch, then a short busy period.
    task automatic serve_tx(output logic [7:0] b, output logic ok);
        wait_tx_en(ok);
        b = tx_data;
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        tx_busy = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_break = 1'b0;
        tx_busy = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        tick();
        total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en: got %0b expected 0", tx_en); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %0h expected 0", tx_data); end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        total++; if (rx_count !== 16'h0 || drop_count !== 16'h0) begin bad++; $display("FAIL reset_counters: got %0h/%0h expected 0/0", rx_count, drop_count); end
    endtask

    task automatic test_single_echo();
        push_byte(8'hA5);
        total++; if (fifo_level !== 5'd1 || tx_en !== 1'b0) begin bad++; $display("FAIL echo_push: got level=%0d tx_en=%0b expected 1/0", fifo_level, tx_en); end
        tick();
        total++; if (tx_en !== 1'b1 || tx_data !== 8'hA5) begin bad++; $display("FAIL echo_launch: got tx_en=%0b data=%0h expected 1/a5", tx_en, tx_data); end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL echo_level: got %0d expected 0", fifo_level); end
        tick();
        total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL echo_one_pulse: got %0b expected 0", tx_en); end
        tx_busy = 1'b1; tick();
        tx_busy = 1'b0; tick();
    endtask

    task automatic test_fill_overflow();
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        total++; if (fifo_level !== 5'd16 || overflow !== 1'b0) begin bad++; $display("FAIL fill_level: got level=%0d ovf=%0b expected 16/0", fifo_level, overflow); end
        push_byte(8'h10);
        total++; if (fifo_level !== 5'd16 || overflow !== 1'b1) begin bad++; $display("FAIL fill_drop: got level=%0d ovf=%0b expected 16/1", fifo_level, overflow); end
    endtask

    task automatic test_ovf_clr();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %0b expected 0", overflow); end
        ovf_clr = 1'b1;
        push_byte(8'h11);
        ovf_clr = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_clr_vs_drop: got %0b expected 1", overflow); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr_again: got %0b expected 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] b;
        logic [7:0] exp_b;
        logic       ok;
        tx_busy = 1'b0;
        push_byte(8'h20);
        total++; if (fifo_level !== 5'd16 || overflow !== 1'b0) begin bad++; $display("FAIL full_push_pop: got level=%0d ovf=%0b expected 16/0", fifo_level, overflow); end
        total++; if (tx_en !== 1'b1 || tx_data !== 8'h00) begin bad++; $display("FAIL full_pop_head: got tx_en=%0b data=%0h expected 1/0", tx_en, tx_data); end
        for (int i = 0; i < 17; i++) begin
            exp_b = (i < 16) ? 8'(i) : 8'h20;
            serve_tx(b, ok);
            total++;
            if (ok !== 1'b1 || b !== exp_b) begin
                bad++; $display("FAIL drain_order[%0d]: got launched=%0b data=%0h expected 1/%0h", i, ok, b, exp_b);
            end
        end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL drain_level: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_break_flush();
        logic ok;
        int   launches;
        push_byte(8'h30);
        wait_tx_en(ok);
        total++; if (ok !== 1'b1 || tx_data !== 8'h30) begin bad++; $display("FAIL brk_inflight: got launched=%0b data=%0h expected 1/30", ok, tx_data); end
        tick();
        tx_busy = 1'b1;
        for (int i = 1; i <= 5; i++) push_byte(8'(8'h30 + i));
        total++; if (fifo_level !== 5'd5) begin bad++; $display("FAIL brk_level5: got %0d expected 5", fifo_level); end
        rx_break = 1'b1;
        push_byte(8'hEE);
        rx_break = 1'b0;
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL brk_flush: got %0d expected 0", fifo_level); end
        tx_busy = 1'b0;
        launches = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tx_en === 1'b1) launches++;
        end
        total++; if (launches != 0 || tx_data !== 8'h30) begin bad++; $display("FAIL brk_no_tx: got launches=%0d data=%0h expected 0/30", launches, tx_data); end
    endtask

    task automatic test_counters();
`ifdef UART_ECHO_STATS_EN
        tx_busy = 1'b1;
        total++; if (rx_count !== 16'd24 || drop_count !== 16'd2) begin bad++; $display("FAIL stats_before: got %0d/%0d expected 24/2", rx_count, drop_count); end
        for (int blk = 0; blk < 4096; blk++) begin
            for (int i = 0; i < 16; i++) push_byte(8'(i));
            rx_break = 1'b1; push_byte(8'h00); rx_break = 1'b0;
            if (blk == 4093) begin
                total++; if (rx_count !== 16'd65528) begin bad++; $display("FAIL stats_mid: got %0d expected 65528", rx_count); end
            end
        end
        total++; if (rx_count !== 16'hFFFF || drop_count !== 16'd2) begin bad++; $display("FAIL stats_sat: got %0h/%0d expected ffff/2", rx_count, drop_count); end
        tx_busy = 1'b0;
`else
        total++; if (rx_count !== 16'h0 || drop_count !== 16'h0) begin bad++; $display("FAIL stats_off: got %0h/%0h expected 0/0", rx_count, drop_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_echo();
        test_fill_overflow();
        test_ovf_clr();
        test_full_push_pop();
        test_break_flush();
        test_counters();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
